// File: rtl/rf68000_ring_server.sv
// Global-resource server: captures ring requests addressed to ID, runs each as one master bus cycle, and returns read data on the response ring.
// Latency: 1 cycle ring pass-through; 2 cycles request-to-bus best case; response 1 cycle after the first empty response slot.
// Backpressure: a full FIFO leaves requests on the ring for retry; a stalled response waits for an empty slot on rpacket_i.

package rf68000_pkg;
    localparam logic [4:0] PT_NULL  = 5'd0;
    localparam logic [4:0] PT_READ  = 5'd1;
    localparam logic [4:0] PT_WRITE = 5'd2;
    localparam logic [4:0] PT_AREAD = 5'd3;
    localparam logic [4:0] PT_ACK   = 5'd4;
    localparam logic [4:0] PT_AACK  = 5'd5;

    typedef struct packed {
        logic [5:0]  sid;
        logic [5:0]  did;
        logic [5:0]  age;
        logic        ack;
        logic        we;
        logic [4:0]  typ;
        logic [3:0]  sel;
        logic [8:0]  pad2;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;
endpackage

module rf68000_ring_server
    import rf68000_pkg::*;
#(
    parameter logic [5:0] ID      = 6'd62,
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 255
) (
    input  logic                     rst_i,
    input  logic                     clk_i,
    input  packet_t                  packet_i,
    output packet_t                  packet_o,
    input  packet_t                  rpacket_i,
    output packet_t                  rpacket_o,
    output logic                     m_cyc_o,
    output logic                     m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic                     m_ack_i,
    input  logic [31:0]              m_dat_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [CW-1:0] CFULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    // Work register: only the request fields the response needs.
    logic [5:0]      req_sid_q, req_sid_d;
    logic            req_write_q, req_write_d;
    logic            req_aread_q, req_aread_d;
    logic [3:0]      req_sel_q, req_sel_d;
    logic [31:0]     req_adr_q, req_adr_d;
    logic [31:0]     rdat_q, rdat_d;

    logic            m_cyc_q, m_cyc_d;
    logic            m_stb_q, m_stb_d;
    logic            m_we_q, m_we_d;
    logic [3:0]      m_sel_q, m_sel_d;
    logic [31:0]     m_adr_q, m_adr_d;
    logic [31:0]     m_dat_q, m_dat_d;

    packet_t         pkt_q, pkt_d;
    packet_t         rpkt_q, rpkt_d;

    packet_t         fifo_mem [DEPTH];
    packet_t         head;

    logic            slot_mine;
    logic            is_req;
    logic            fifo_full;
    logic            push;
    logic            drop;
    logic            pop;
    logic            rslot_empty;
    logic            unused_head;

    assign head        = fifo_mem[rd_ptr_q];
    assign unused_head = ^{head.did, head.age, head.ack, head.we, head.pad2};

    // Capture decision for the request ring; uses pre-pop occupancy so a full FIFO never accepts.
    always_comb begin
        slot_mine   = ((packet_i.sid | packet_i.did) != 6'd0) && (packet_i.did == ID)
                      && (packet_i.did != 6'd63);
        is_req      = (packet_i.typ == PT_READ) || (packet_i.typ == PT_AREAD)
                      || (packet_i.typ == PT_WRITE);
        fifo_full   = (count_q == CFULL);
        push        = slot_mine && is_req && !fifo_full;
        drop        = slot_mine && !is_req;
        pop         = (state_q == S_IDLE) && (count_q != '0) && !m_ack_i;
        rslot_empty = ((rpacket_i.sid | rpacket_i.did) == 6'd0);
        pkt_d       = (push || drop) ? '0 : packet_i;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage; contents behind the pointers are don't-care so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= packet_i;
        end
    end

    // Executor next-state: pop into the work register, run the bus cycle, then emit the read response.
    always_comb begin
        packet_t resp;
        resp        = '0;
        state_d     = state_q;
        tmo_d       = tmo_q;
        req_sid_d   = req_sid_q;
        req_write_d = req_write_q;
        req_aread_d = req_aread_q;
        req_sel_d   = req_sel_q;
        req_adr_d   = req_adr_q;
        rdat_d      = rdat_q;
        m_cyc_d     = m_cyc_q;
        m_stb_d     = m_stb_q;
        m_we_d      = m_we_q;
        m_sel_d     = m_sel_q;
        m_adr_d     = m_adr_q;
        m_dat_d     = m_dat_q;
        rpkt_d      = rpacket_i;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    req_sid_d   = head.sid;
                    req_write_d = (head.typ == PT_WRITE);
                    req_aread_d = (head.typ == PT_AREAD);
                    req_sel_d   = head.sel;
                    req_adr_d   = head.adr;
                    m_cyc_d     = 1'b1;
                    m_stb_d     = 1'b1;
                    m_we_d      = (head.typ == PT_WRITE);
                    m_adr_d     = head.adr;
                    m_sel_d     = (head.typ == PT_WRITE) ? head.sel : 4'hF;
                    m_dat_d     = (head.typ == PT_WRITE) ? head.dat : m_dat_q;
                    tmo_d       = '0;
                    state_d     = S_BUS;
                end
            end
            S_BUS: begin
                tmo_d = tmo_q + 1'b1;
                // Ack wins over a coincident timeout so real data is never replaced.
                if (m_ack_i || (tmo_q == TMAX)) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    m_we_d  = 1'b0;
                    m_sel_d = 4'h0;
                    if (req_write_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rdat_d  = m_ack_i ? m_dat_i : 32'hFFFF_FFFF;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rslot_empty) begin
                    resp.sid = ID;
                    resp.did = req_sid_q;
                    resp.typ = req_aread_q ? PT_AACK : PT_ACK;
                    resp.ack = 1'b1;
                    resp.sel = req_sel_q;
                    resp.adr = req_adr_q;
                    resp.dat = rdat_q;
                    rpkt_d   = resp;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            req_sid_q   <= '0;
            req_write_q <= 1'b0;
            req_aread_q <= 1'b0;
            req_sel_q   <= '0;
            req_adr_q   <= '0;
            rdat_q      <= '0;
            m_cyc_q     <= 1'b0;
            m_stb_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_sel_q     <= '0;
            m_adr_q     <= '0;
            m_dat_q     <= '0;
            pkt_q       <= '0;
            rpkt_q      <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            req_sid_q   <= req_sid_d;
            req_write_q <= req_write_d;
            req_aread_q <= req_aread_d;
            req_sel_q   <= req_sel_d;
            req_adr_q   <= req_adr_d;
            rdat_q      <= rdat_d;
            m_cyc_q     <= m_cyc_d;
            m_stb_q     <= m_stb_d;
            m_we_q      <= m_we_d;
            m_sel_q     <= m_sel_d;
            m_adr_q     <= m_adr_d;
            m_dat_q     <= m_dat_d;
            pkt_q       <= pkt_d;
            rpkt_q      <= rpkt_d;
        end
    end

    assign packet_o  = pkt_q;
    assign rpacket_o = rpkt_q;
    assign m_cyc_o   = m_cyc_q;
    assign m_stb_o   = m_stb_q;
    assign m_we_o    = m_we_q;
    assign m_sel_o   = m_sel_q;
    assign m_adr_o   = m_adr_q;
    assign m_dat_o   = m_dat_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_rf68000_ring_server.sv
// Bench for rf68000_ring_server: directed scenarios plus random ring/bus traffic.
// Reference is transactional: a queue of expected bus cycles and a queue of expected responses.
// Bus responder acks after a chosen latency, sometimes never, and injects stray acks while idle.

module tb_rf68000_ring_server;
    import rf68000_pkg::*;

    localparam logic [5:0] ID      = 6'd62;
    localparam int         DEPTH   = 4;
    localparam int         TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    packet_t     pin, pout, rpin, rpout;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dato, dati;
    logic [2:0]  cnt;

    rf68000_ring_server #(.ID(ID), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .rst_i(rst), .clk_i(clk),
        .packet_i(pin), .packet_o(pout),
        .rpacket_i(rpin), .rpacket_o(rpout),
        .m_cyc_o(cyc), .m_stb_o(stb), .m_we_o(we), .m_sel_o(sel),
        .m_adr_o(adr), .m_dat_o(dato), .m_ack_i(ack), .m_dat_i(dati),
        .count_o(cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Reference state
    packet_t     bus_q[$];
    packet_t     resp_q[$];
    packet_t     cur;
    int          occ = 0;
    logic        cyc_prev = 1'b0;
    logic        ack_prev = 1'b0;
    logic [31:0] ack_dat_prev = '0;
    int          cyc_len = 0;
    logic        resp_wait = 1'b0;
    logic        expect_rise = 1'b0;
    int          lat = 0;
    logic        acked = 1'b0;
    logic        cur_noack = 1'b0;
    int          n_resp = 0;
    int          n_wr = 0;

    // Knobs
    int          lat_fix = -1;
    bit          no_ack_mode = 0;
    bit          rand_noack = 0;
    bit          dat_fixed = 0;
    logic [31:0] fix_dat = '0;
    int          stray_pct = 0;

    function automatic bit is_req(logic [4:0] t);
        return (t == PT_READ) || (t == PT_AREAD) || (t == PT_WRITE);
    endfunction

    function automatic bit empty_slot(packet_t p);
        return (p.sid | p.did) == 6'd0;
    endfunction

    // kind: 0 empty, 1 read, 2 aread, 3 write, 4 non-request to ID, 5 broadcast, else foreign
    function automatic packet_t mk(int kind);
        packet_t p;
        p = '0;
        if (kind == 0) return p;
        p.sid  = 6'($urandom_range(1, 61));
        p.age  = 6'($urandom);
        p.sel  = 4'($urandom);
        p.pad2 = 9'($urandom);
        p.adr  = $urandom;
        p.dat  = $urandom;
        case (kind)
            1: begin p.did = ID; p.typ = PT_READ; end
            2: begin p.did = ID; p.typ = PT_AREAD; end
            3: begin p.did = ID; p.typ = PT_WRITE; p.we = 1'b1; end
            4: begin p.did = ID; p.typ = ($urandom_range(0, 1) != 0) ? PT_ACK : PT_AACK; end
            5: begin p.did = 6'd63; p.typ = 5'($urandom_range(1, 5)); end
            default: begin p.did = 6'd5; p.typ = 5'($urandom_range(1, 5)); end
        endcase
        return p;
    endfunction

    function automatic packet_t mk_rand();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2: return mk(0);
            3, 9:    return mk(1);
            4:       return mk(2);
            5:       return mk(3);
            6:       return mk(4);
            7:       return mk(5);
            default: return mk(6);
        endcase
    endfunction

    // Observe outputs after an edge and compare against the reference.
    task automatic monitor();
        bit      acc, rose;
        packet_t exp_p, r;
        if (rst) begin
            check("rst_pkt_o", pout, '0);
            check("rst_rpkt_o", rpout, '0);
            check("rst_bus", {cyc, stb, we, sel, adr, dato}, '0);
            check("rst_count", cnt, 0);
            occ = 0; bus_q.delete(); resp_q.delete();
            cyc_prev = 0; ack_prev = 0; resp_wait = 0; expect_rise = 0;
            cyc_len = 0; acked = 0;
            return;
        end
        // request ring
        acc   = (pin.did == ID) && is_req(pin.typ) && (occ < DEPTH);
        exp_p = ((pin.did == ID) && (acc || !is_req(pin.typ))) ? '0 : pin;
        check("pkt_o", pout, exp_p);
        if (acc) bus_q.push_back(pin);
        // bus start
        rose = cyc && !cyc_prev;
        check("bus_start", rose, expect_rise);
        check("stb_eq_cyc", stb, cyc);
        if (rose) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 1, 0);
            end else begin
                cur = bus_q.pop_front();
                occ--;
                check("bus_we", we, cur.typ == PT_WRITE);
                check("bus_adr", adr, cur.adr);
                check("bus_sel", sel, (cur.typ == PT_WRITE) ? cur.sel : 4'hF);
                if (cur.typ == PT_WRITE) begin
                    check("bus_dat", dato, cur.dat);
                    n_wr++;
                end
            end
            cyc_len   = 0;
            acked     = 0;
            lat       = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 5);
            cur_noack = no_ack_mode || (rand_noack && ($urandom_range(0, 99) < 2));
        end
        if (acc) occ++;
        check("count_o", cnt, occ);
        // response ring
        if (!empty_slot(rpin)) begin
            check("rpkt_fwd", rpout, rpin);
        end else if (resp_wait) begin
            check("rpkt_resp", rpout, resp_q.pop_front());
            resp_wait = 0;
            n_resp++;
        end else begin
            check("rpkt_idle", rpout, '0);
        end
        // bus end
        if (cyc) cyc_len++;
        if (cyc_prev && ack_prev) check("ack_drop", cyc, 0);
        if (cyc && cyc_len > TIMEOUT + 1) check("tmo_over", cyc_len, TIMEOUT + 1);
        if (cyc_prev && !cyc) begin
            if (!ack_prev) check("tmo_len", cyc_len, TIMEOUT + 1);
            check("bus_idle", {stb, we, sel}, '0);
            if (cur.typ != PT_WRITE) begin
                r     = '0;
                r.sid = ID;
                r.did = cur.sid;
                r.typ = (cur.typ == PT_AREAD) ? PT_AACK : PT_ACK;
                r.ack = 1'b1;
                r.sel = cur.sel;
                r.adr = cur.adr;
                r.dat = ack_prev ? ack_dat_prev : 32'hFFFF_FFFF;
                resp_q.push_back(r);
                resp_wait = 1;
            end
        end
        cyc_prev = cyc;
    endtask

    // Drive one cycle of inputs, act as bus slave, then step the clock and check.
    task automatic step(packet_t p, packet_t rp);
        pin  = p;
        rpin = rp;
        ack  = 1'b0;
        if (!rst && cyc && !acked && !cur_noack) begin
            if (lat == 0) begin
                ack   = 1'b1;
                dati  = dat_fixed ? fix_dat : $urandom;
                acked = 1;
            end else begin
                lat--;
            end
        end else if (!rst && !cyc && ($urandom_range(0, 99) < stray_pct)) begin
            ack = 1'b1;
        end
        ack_prev     = ack;
        ack_dat_prev = dati;
        expect_rise  = !rst && !cyc && !resp_wait && (occ > 0) && !ack;
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(mk(0), mk(0));
    endtask

    function automatic bit busy();
        return (bus_q.size() != 0) || resp_wait || cyc || (occ != 0);
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        packet_t p, p5;
        pin = '0; rpin = '0; ack = 1'b0; dati = '0;

        // reset
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        // single read, ack after 2 cycles with fixed data
        dat_fixed = 1; fix_dat = 32'h1234_5678; lat_fix = 2;
        p = mk(1); p.sid = 6'd3; p.adr = 32'hFD00_0010;
        step(p, mk(0));
        idle(12);
        check("single_read_resps", n_resp, 1);

        // aread then write sel=3 dat=A5A5
        p = mk(2);
        step(p, mk(0));
        p = mk(3); p.sel = 4'h3; p.dat = 32'h0000_A5A5;
        step(p, mk(0));
        idle(15);
        check("aread_write_resps", n_resp, 2);
        check("aread_write_writes", n_wr, 1);
        dat_fixed = 0;

        // FIFO full: first request stalls the bus, next five arrive back-to-back
        lat_fix = 20;
        step(mk(1), mk(0));
        for (int i = 0; i < 4; i++) step(mk(1 + (i % 3)), mk(0));
        p5 = mk(1);
        step(p5, mk(0));
        check("full_count", cnt, 4);
        check("full_pass", pout, p5);
        lat_fix = 1;
        idle(40);
        check("full_drained", occ, 0);

        // response slot stall: response ring full for several cycles after the ack
        step(mk(1), mk(0));
        for (int i = 0; i < 14; i++) step(mk(0), mk(6));
        idle(4);
        lat_fix = -1;

        // timeout
        no_ack_mode = 1;
        step(mk(1), mk(0));
        idle(262);
        no_ack_mode = 0;
        idle(4);

        // reset during a bus cycle
        lat_fix = 30;
        step(mk(1), mk(0));
        idle(5);
        check("pre_rst_cyc", cyc, 1);
        rst = 1'b1;
        step(mk(5), mk(6));
        rst = 1'b0;
        lat_fix = -1;
        idle(40);

        // random traffic
        stray_pct  = 10;
        rand_noack = 1;
        for (int i = 0; i < 3000; i++) begin
            step(mk_rand(), ($urandom_range(0, 99) < 30) ? mk(6) : mk(0));
        end
        rand_noack = 0;
        stray_pct  = 0;

        // drain
        for (int i = 0; i < 2000 && busy(); i++) idle(1);
        check("drain_busy", busy(), 0);
        check("drain_resp_q", resp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
